// File: rtl/ext_bus_responder.sv
// rtl/ext_bus_responder.sv - bridges a level-held external request bus onto an Avalon-MM style master with timeout
module ext_bus_responder #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ext_address,
    input  logic        ext_byte_enable,
    input  logic        ext_read,
    input  logic        ext_write,
    input  logic [7:0]  ext_write_data,
    output logic        ext_acknowledge,
    output logic [7:0]  ext_read_data,
    output logic [15:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [7:0]  avm_writedata,
    output logic        avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [7:0]  avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RDATA,
        S_ACK,
        S_HOLD
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          op_read_q;
    logic          ack_q;
    logic [7:0]    rdata_q;
    logic [15:0]   addr_q;
    logic [7:0]    wdata_q;
    logic          be_q;
    logic          avm_read_q;
    logic          avm_write_q;
    logic          timeout_err_q;
    logic          rsp_done;

    // Read data is only accepted while a transfer is outstanding; stray strobes elsewhere are dropped.
    assign rsp_done = ((state_q == S_CMD) && !avm_waitrequest && (!op_read_q || avm_readdatavalid))
                   || ((state_q == S_RDATA) && avm_readdatavalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_read_q     <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= 8'h00;
            addr_q        <= 16'h0000;
            wdata_q       <= 8'h00;
            be_q          <= 1'b0;
            avm_read_q    <= 1'b0;
            avm_write_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (ext_read || ext_write) begin
                        addr_q      <= ext_address;
                        wdata_q     <= ext_write_data;
                        be_q        <= ext_byte_enable;
                        op_read_q   <= ext_read;
                        avm_read_q  <= ext_read;
                        avm_write_q <= ext_write && !ext_read;
                        cnt_q       <= '0;
                        state_q     <= S_CMD;
                    end
                end
                S_CMD, S_RDATA: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rsp_done) begin
                        avm_read_q  <= 1'b0;
                        avm_write_q <= 1'b0;
                        ack_q       <= 1'b1;
                        state_q     <= S_ACK;
                        if (op_read_q) begin
                            rdata_q <= avm_readdata;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        // Timeout overrides a simultaneous err_clr because it is assigned later.
                        avm_read_q    <= 1'b0;
                        avm_write_q   <= 1'b0;
                        ack_q         <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_ACK;
                        if (op_read_q) begin
                            rdata_q <= 8'hFF;
                        end
                    end else if ((state_q == S_CMD) && !avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        state_q    <= S_RDATA;
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (!ext_read && !ext_write) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ext_acknowledge = ack_q;
    assign ext_read_data   = rdata_q;
    assign avm_address     = addr_q;
    assign avm_read        = avm_read_q;
    assign avm_write       = avm_write_q;
    assign avm_writedata   = wdata_q;
    assign avm_byteenable  = be_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_ext_bus_responder.sv
// tb/tb_ext_bus_responder.sv - directed self-checking bench for ext_bus_responder
module tb_ext_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ext_address;
    logic        ext_byte_enable;
    logic        ext_read;
    logic        ext_write;
    logic [7:0]  ext_write_data;
    logic        ext_acknowledge;
    logic [7:0]  ext_read_data;
    logic [15:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [7:0]  avm_writedata;
    logic        avm_byteenable;
    logic        avm_waitrequest;
    logic [7:0]  avm_readdata;
    logic        avm_readdatavalid;
    logic        timeout_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    ext_bus_responder #(.TIMEOUT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ext_address      (ext_address),
        .ext_byte_enable  (ext_byte_enable),
        .ext_read         (ext_read),
        .ext_write        (ext_write),
        .ext_write_data   (ext_write_data),
        .ext_acknowledge  (ext_acknowledge),
        .ext_read_data    (ext_read_data),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_byteenable   (avm_byteenable),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .timeout_err      (timeout_err),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic test_reset;
        #2;
        checks++;
        if ({ext_acknowledge, avm_read, avm_write, timeout_err, avm_byteenable} !== 5'b0 ||
            ext_read_data !== 8'h00 || avm_address !== 16'h0000 || avm_writedata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b rd=%b wr=%b err=%b be=%b rdata=%h addr=%h wdata=%h expected all 0",
                     ext_acknowledge, avm_read, avm_write, timeout_err, avm_byteenable,
                     ext_read_data, avm_address, avm_writedata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        ext_write = 1'b1; ext_address = 16'h8004; ext_write_data = 8'h5A; ext_byte_enable = 1'b1;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        checks++;
        if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_address !== 16'h8004 ||
            avm_writedata !== 8'h5A || avm_byteenable !== 1'b1 || ext_acknowledge !== 1'b0) begin
            errors++;
            $display("FAIL write_cmd: wr=%b rd=%b addr=%h data=%h be=%b ack=%b expected 1 0 8004 5a 1 0",
                     avm_write, avm_read, avm_address, avm_writedata, avm_byteenable, ext_acknowledge);
        end
        ext_address = 16'hFFFF; ext_write_data = 8'h00;
        @(negedge clk);
        checks++;
        if (ext_acknowledge !== 1'b1 || avm_write !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: ack=%b wr=%b expected 1 0", ext_acknowledge, avm_write);
        end
        @(negedge clk);
        checks++;
        if (ext_acknowledge !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_pulse: ack=%b expected 0", ext_acknowledge);
        end
        ext_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_wait;
        int bad;
        bad = 0;
        ext_read = 1'b1; ext_address = 16'h1234; avm_waitrequest = 1'b1;
        avm_readdatavalid = 1'b0; avm_readdata = 8'h11;
        @(negedge clk);
        ext_address = 16'hABCD;
        for (int i = 0; i < 4; i++) begin
            if (avm_read !== 1'b1 || avm_address !== 16'h1234 || ext_acknowledge !== 1'b0) bad++;
            if (i == 3) avm_waitrequest = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL read_wait_hold: bad cycles=%0d expected 0", bad);
        end
        checks++;
        if (avm_read !== 1'b0 || ext_acknowledge !== 1'b0) begin
            errors++;
            $display("FAIL read_rdata_state: rd=%b ack=%b expected 0 0", avm_read, ext_acknowledge);
        end
        @(negedge clk);
        checks++;
        if (ext_read_data !== 8'h00 || ext_acknowledge !== 1'b0) begin
            errors++;
            $display("FAIL read_no_early_capture: rdata=%h ack=%b expected 00 0", ext_read_data, ext_acknowledge);
        end
        avm_readdatavalid = 1'b1; avm_readdata = 8'hC3;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        checks++;
        if (ext_acknowledge !== 1'b1 || ext_read_data !== 8'hC3) begin
            errors++;
            $display("FAIL read_wait_ack: ack=%b rdata=%h expected 1 c3", ext_acknowledge, ext_read_data);
        end
        ext_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_held_read;
        int nrd;
        int nack;
        nrd = 0; nack = 0;
        ext_read = 1'b1; ext_address = 16'h0042; avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 8'h77;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nrd += int'(avm_read);
            nack += int'(ext_acknowledge);
        end
        checks++;
        if (nrd !== 1 || nack !== 1 || ext_read_data !== 8'h77) begin
            errors++;
            $display("FAIL held_read_once: reads=%0d acks=%0d rdata=%h expected 1 1 77", nrd, nack, ext_read_data);
        end
        ext_read = 1'b0;
        @(negedge clk);
        ext_read = 1'b1; avm_readdata = 8'h3C;
        @(negedge clk);
        checks++;
        if (avm_read !== 1'b1) begin
            errors++;
            $display("FAIL held_read_reissue: rd=%b expected 1", avm_read);
        end
        @(negedge clk);
        checks++;
        if (ext_acknowledge !== 1'b1 || ext_read_data !== 8'h3C) begin
            errors++;
            $display("FAIL held_read_second_ack: ack=%b rdata=%h expected 1 3c", ext_acknowledge, ext_read_data);
        end
        ext_read = 1'b0; avm_readdatavalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int early;
        early = 0;
        ext_read = 1'b1; ext_address = 16'h0100; avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0; avm_readdata = 8'hAA;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            early += int'(ext_acknowledge);
            @(negedge clk);
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL timeout_early_ack: acks=%0d expected 0", early);
        end
        checks++;
        if (ext_acknowledge !== 1'b1 || ext_read_data !== 8'hFF || timeout_err !== 1'b1 || avm_read !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack: ack=%b rdata=%h err=%b rd=%b expected 1 ff 1 0",
                     ext_acknowledge, ext_read_data, timeout_err, avm_read);
        end
        ext_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        avm_readdatavalid = 1'b1; avm_readdata = 8'h55;
        @(negedge clk);
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        checks++;
        if (ext_acknowledge !== 1'b0 || ext_read_data !== 8'hFF || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_late_data: ack=%b rdata=%h err=%b expected 0 ff 1",
                     ext_acknowledge, ext_read_data, timeout_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clr: err=%b expected 0", timeout_err);
        end
    endtask

    task automatic test_timeout_clr_race;
        int nwr;
        nwr = 0;
        ext_write = 1'b1; ext_address = 16'h0200; ext_write_data = 8'h12; avm_waitrequest = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            nwr += int'(avm_write);
            @(negedge clk);
        end
        err_clr = 1'b0;
        checks++;
        if (nwr !== 8) begin
            errors++;
            $display("FAIL race_write_held: write cycles=%0d expected 8", nwr);
        end
        checks++;
        if (ext_acknowledge !== 1'b1 || timeout_err !== 1'b1 || avm_write !== 1'b0 || ext_read_data !== 8'hFF) begin
            errors++;
            $display("FAIL race_set_wins: ack=%b err=%b wr=%b rdata=%h expected 1 1 0 ff",
                     ext_acknowledge, timeout_err, avm_write, ext_read_data);
        end
        ext_write = 1'b0; avm_waitrequest = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_both;
        ext_read = 1'b1; ext_write = 1'b1; ext_address = 16'h0300; avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 8'h9E;
        @(negedge clk);
        checks++;
        if (avm_read !== 1'b1 || avm_write !== 1'b0) begin
            errors++;
            $display("FAIL both_read_wins: rd=%b wr=%b expected 1 0", avm_read, avm_write);
        end
        @(negedge clk);
        checks++;
        if (ext_acknowledge !== 1'b1 || ext_read_data !== 8'h9E) begin
            errors++;
            $display("FAIL both_ack: ack=%b rdata=%h expected 1 9e", ext_acknowledge, ext_read_data);
        end
        ext_read = 1'b0; ext_write = 1'b0; avm_readdatavalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int nack;
        nack = 0;
        ext_read = 1'b1; ext_address = 16'h2222; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ext_acknowledge, avm_read, avm_write, timeout_err, avm_byteenable} !== 5'b0 ||
            ext_read_data !== 8'h00 || avm_address !== 16'h0000 || avm_writedata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_outputs: ack=%b rd=%b wr=%b err=%b be=%b rdata=%h addr=%h wdata=%h expected all 0",
                     ext_acknowledge, avm_read, avm_write, timeout_err, avm_byteenable,
                     ext_read_data, avm_address, avm_writedata);
        end
        ext_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        avm_readdatavalid = 1'b1; avm_readdata = 8'h66;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nack += int'(ext_acknowledge);
        end
        avm_readdatavalid = 1'b0;
        checks++;
        if (nack !== 0 || ext_read_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_late_data: acks=%0d rdata=%h expected 0 00", nack, ext_read_data);
        end
    endtask

    initial begin
        rst_n = 1'b0; ext_address = 16'h0000; ext_byte_enable = 1'b0; ext_read = 1'b0;
        ext_write = 1'b0; ext_write_data = 8'h00; avm_waitrequest = 1'b0; avm_readdata = 8'h00;
        avm_readdatavalid = 1'b0; err_clr = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_held_read();
        test_timeout();
        test_timeout_clr_race();
        test_both();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
